// File: rtl/uart_word_reader_pkg.sv
// Shared UART receive definitions: bit-FSM state encoding and default baud divisor.
package uart_word_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // 50 MHz clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 UART deserialiser: 2-flop synchroniser, bit FSM and baud counter.
// Emits the received byte with a one-cycle byte_ok or frame_err strobe.
module uart_rx_deser
  import uart_word_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err,
  output logic       idle,
  output logic       start_edge
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2);
  localparam logic [BAUD_W-1:0] LAST_CLK = BAUD_W'(CLKS_PER_BIT - 1);

  logic              rx_p0, rx_p1, rx_p2;
  rx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_p0;
  logic              bit_end;

  // rx_p2 is only the previous synchronised level, so a held-low line never retriggers
  assign start_edge = rx_p2 & ~rx_p1;
  assign idle       = (state == ST_IDLE);
  assign bit_end    = (baud_cnt == LAST_CLK);
  assign byte_ok    = (state == ST_STOP) && bit_end && rx_p1;
  assign frame_err  = (state == ST_STOP) && bit_end && !rx_p1;
  assign rx_byte    = shift_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_p2    <= 1'b1;
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (start_edge) state <= ST_START;
        end
        ST_START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (state == ST_DATA && bit_end) shift_p0 <= {rx_p1, shift_p0[7:1]};
  end

endmodule

// File: rtl/uart_word_reader.sv
// UART word reader: packs WORD_BYTES received bytes into a word behind a valid/ready register.
// Optional partial-word timeout enabled by defining UART_READER_TIMEOUT_EN.
module uart_word_reader
  import uart_word_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WORD_BYTES   = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  logic [7:0]        rx_byte;
  logic              byte_ok, byte_bad, rx_idle, start_edge;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] asm_p0, asm_next;
  logic              word_done, word_blocked, idle_expired;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_ok    (byte_ok),
    .frame_err  (byte_bad),
    .idle       (rx_idle),
    .start_edge (start_edge)
  );

  always_comb begin
    asm_next = asm_p0;
    asm_next[8*byte_cnt +: 8] = rx_byte;
  end

  assign word_done    = byte_ok && (byte_cnt == LAST_BYTE);
  assign word_blocked = word_valid && !word_ready;

  always_ff @(posedge clk) begin
    if (byte_ok) asm_p0 <= asm_next;
  end

`ifdef UART_READER_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;

  assign idle_expired = rx_idle && (byte_cnt != '0) && !start_edge &&
                        (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!rx_idle || byte_cnt == '0 || start_edge || idle_expired) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  localparam int unused_timeout_bits = TIMEOUT_BITS;
  logic unused_idle_sigs;

  assign idle_expired     = 1'b0;
  assign unused_idle_sigs = &{1'b0, rx_idle, start_edge};
`endif

  // A word finishing while the previous one is still unconsumed is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      frame_err <= byte_bad;
      overrun   <= word_done && word_blocked;
      timeout   <= idle_expired;
      if (idle_expired) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        byte_cnt <= word_done ? '0 : byte_cnt + CNT_W'(1);
      end
      if (word_done && !word_blocked) begin
        word_data  <= asm_next;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_reader.sv
// Self-checking bench for uart_word_reader (CLKS_PER_BIT=16, WORD_BYTES=4).
// Define UART_READER_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_uart_word_reader;

  localparam int CPB = 16;
  localparam int WB  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [31:0]   word_data;
  logic          word_valid;
  logic          word_ready;
  logic          frame_err;
  logic          overrun;
  logic          timeout;

  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_ferr = 0, n_ovr = 0, n_to = 0;
  int            rise_cyc = 0, vld_len = 0, last_len = 0;
  logic          prev_valid = 1'b0;
  logic [31:0]   got_q[$];
  logic [31:0]   exp_q[$];
  logic [7:0]    part_q[$];

  uart_word_reader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .TIMEOUT_BITS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: pulse counts, valid timing and accepted words
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      vld_len    = 0;
    end else begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (timeout)   n_to++;
      if (word_valid && !prev_valid) rise_cyc = cyc;
      if (word_valid) vld_len++;
      else if (prev_valid) begin
        last_len = vld_len;
        vld_len  = 0;
      end
      if (word_valid && word_ready) got_q.push_back(word_data);
      prev_valid = word_valid;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame followed by one idle bit-time
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  // Reference model: good bytes accumulate, every WB of them form a word (first byte lowest)
  task automatic model_byte(input logic [7:0] b, input logic good);
    logic [31:0] w;
    if (good) begin
      part_q.push_back(b);
      if (part_q.size() == WB) begin
        w = 32'(part_q[0]) + (32'(part_q[1]) << 8) + (32'(part_q[2]) << 16) + (32'(part_q[3]) << 24);
        exp_q.push_back(w);
        part_q.delete();
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < WB; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    check({tag, "_count"}, 64'(got_q.size()), 64'd1);
    if (got_q.size() != 0) check(tag, 64'(got_q.pop_front()), 64'(exp));
    got_q.delete();
  endtask

  initial begin
    int ferr0, ovr0, to0, t0;
    logic [31:0] w;
    logic [7:0]  b;
    logic        good;
    int          good_cnt, nbytes;

    rst = 1'b1;
    rx = 1'b1;
    word_ready = 1'b0;
    tick(4);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_data", 64'(word_data), 64'd0);
    check("rst_flags", 64'({frame_err, overrun, timeout}), 64'd0);
    rst = 1'b0;
    tick(2 * CPB);

    // 1: basic word with ready high, latency and single-cycle valid
    word_ready = 1'b1;
    ferr0 = n_ferr; ovr0 = n_ovr;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    t0 = cyc;
    send_byte(8'h44, 1'b1);
    expect_word("t1_word", 32'h44332211);
    check("t1_latency", 64'(rise_cyc - t0), 64'd156);
    check("t1_valid_len", 64'(last_len), 64'd1);
    check("t1_flags", 64'((n_ferr - ferr0) + (n_ovr - ovr0)), 64'd0);

    // 2: consumer stalled, second word overruns and is dropped
    word_ready = 1'b0;
    ovr0 = n_ovr;
    send_word(32'h44332211);
    check("t2_valid_held", 64'(word_valid), 64'd1);
    w = $urandom;
    send_word(w);
    check("t2_overrun", 64'(n_ovr - ovr0), 64'd1);
    check("t2_data_kept", 64'(word_data), 64'h44332211);
    check("t2_valid_still", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    tick(1);
    check("t2_valid_drop", 64'(word_valid), 64'd0);
    check("t2_data_hold", 64'(word_data), 64'h44332211);
    expect_word("t2_word", 32'h44332211);

    // 3: framing error drops the byte without advancing the packer
    ferr0 = n_ferr;
    send_byte(8'hA5, 1'b0);
    check("t3_ferr", 64'(n_ferr - ferr0), 64'd1);
    send_word(32'h04030201);
    expect_word("t3_word", 32'h04030201);
    check("t3_ferr_once", 64'(n_ferr - ferr0), 64'd1);

    // 4: short low glitch is rejected at the start-bit check
    ferr0 = n_ferr; ovr0 = n_ovr; to0 = n_to;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    check("t4_no_word", 64'(got_q.size()), 64'd0);
    check("t4_no_flags", 64'((n_ferr - ferr0) + (n_ovr - ovr0) + (n_to - to0)), 64'd0);
    w = $urandom;
    send_word(w);
    expect_word("t4_aligned", w);

    // 5: partial word followed by a long idle gap
    to0 = n_to;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(22 * CPB);
`ifdef UART_READER_TIMEOUT_EN
    check("t5_timeout", 64'(n_to - to0), 64'd1);
    send_word(32'h04030201);
    expect_word("t5_word", 32'h04030201);
`else
    check("t5_no_timeout", 64'(n_to - to0), 64'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    expect_word("t5_word", 32'h0201BBAA);
`endif

    // Randomised streams with occasional framing errors against the model
    for (int r = 0; r < 3; r++) begin
      ferr0 = n_ferr;
      exp_q.delete();
      part_q.delete();
      good_cnt = 0;
      nbytes = 0;
      while (good_cnt < 8 || (good_cnt % WB) != 0) begin
        b = 8'($urandom);
        good = ($urandom_range(0, 5) != 0);
        send_byte(b, good);
        model_byte(b, good);
        if (good) good_cnt++;
        nbytes++;
      end
      check($sformatf("rnd%0d_ferr", r), 64'(n_ferr - ferr0), 64'(nbytes - good_cnt));
      check($sformatf("rnd%0d_count", r), 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i < got_q.size()) check($sformatf("rnd%0d_w%0d", r, i), 64'(got_q[i]), 64'(exp_q[i]));
      end
      got_q.delete();
    end

    // 6: reset in the middle of byte 2 with a pending word
    word_ready = 1'b0;
    send_word(32'hCAFEF00D);
    check("t6_pending", 64'(word_valid), 64'd1);
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick(CPB);
    end
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    check("t6_rst_valid", 64'(word_valid), 64'd0);
    check("t6_rst_data", 64'(word_data), 64'd0);
    tick(3);
    check("t6_rst_flags", 64'({frame_err, overrun, timeout}), 64'd0);
    rst = 1'b0;
    tick(2 * CPB);
    word_ready = 1'b1;
    ferr0 = n_ferr;
    w = $urandom;
    send_word(w);
    expect_word("t6_clean_word", w);
    check("t6_no_ferr", 64'(n_ferr - ferr0), 64'd0);

`ifndef UART_READER_TIMEOUT_EN
    check("timeout_tied", 64'(n_to), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
